// File: rtl/br_issue_sched.sv
// br_issue_sched: branch reservation station with oldest-ready issue and CDB wakeup
package br_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        bp;
    logic [31:0] bp_addr;
  } decode_info_t;
endpackage

module br_issue_sched #(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  br_pkg::decode_info_t             disp_info,
  input  logic [PHYS_REG_BITS-1:0]         disp_rs1_paddr,
  input  logic [PHYS_REG_BITS-1:0]         disp_rs2_paddr,
  input  logic                             disp_rs1_rdy,
  input  logic                             disp_rs2_rdy,
  input  logic [PHYS_REG_BITS-1:0]         disp_pd,
  input  logic [ROB_IDX_BITS-1:0]          disp_rob_idx,
  input  logic                             cdb_valid,
  input  logic [PHYS_REG_BITS-1:0]         cdb_pd,
  input  logic                             fu_busy,
  output logic                             fu_start,
  output br_pkg::decode_info_t             fu_info,
  output logic [PHYS_REG_BITS-1:0]         fu_rs1_paddr,
  output logic [PHYS_REG_BITS-1:0]         fu_rs2_paddr,
  output logic [PHYS_REG_BITS-1:0]         fu_pd,
  output logic [ROB_IDX_BITS-1:0]          fu_rob_idx,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic                     valid;
    br_pkg::decode_info_t     info;
    logic [PHYS_REG_BITS-1:0] rs1;
    logic [PHYS_REG_BITS-1:0] rs2;
    logic                     r1;
    logic                     r2;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
  } ent_t;
  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          ext   [DEPTH+1];
  ent_t          disp_ent;
  logic [CW-1:0] count_q, count_d, wr;
  logic [IW-1:0] sel;
  logic          hold_q, any_ready, disp_fire;

  assign fu_start     = any_ready && !fu_busy && !hold_q && !flush;
  assign disp_ready   = count_q < CW'(DEPTH);
  assign disp_fire    = disp_valid && disp_ready && !flush;
  assign wr           = count_q - CW'(fu_start);
  assign count_d      = flush ? '0 : count_q + CW'(disp_fire) - CW'(fu_start);
  assign count        = count_q;
  assign fu_info      = any_ready ? ent_q[sel].info : '0;
  assign fu_rs1_paddr = any_ready ? ent_q[sel].rs1  : '0;
  assign fu_rs2_paddr = any_ready ? ent_q[sel].rs2  : '0;
  assign fu_pd        = any_ready ? ent_q[sel].pd   : '0;
  assign fu_rob_idx   = any_ready ? ent_q[sel].rob  : '0;
  assign disp_ent     = '{valid: 1'b1, info: disp_info, rs1: disp_rs1_paddr, rs2: disp_rs2_paddr,
                          r1: disp_rs1_rdy || (cdb_valid && cdb_pd == disp_rs1_paddr),
                          r2: disp_rs2_rdy || (cdb_valid && cdb_pd == disp_rs2_paddr),
                          pd: disp_pd, rob: disp_rob_idx};

  // oldest (lowest index) entry with both operands ready from registered bits
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2) begin
        any_ready = 1'b1;
        sel       = IW'(i);
      end
  end

  // collapse above the issued slot, then wake shifted entries, then insert dispatch
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = ent_q[i];
    ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (fu_start && i >= int'(sel)) ? ext[i+1] : ext[i];
      if (cdb_valid && ent_d[i].rs1 == cdb_pd) ent_d[i].r1 = 1'b1;
      if (cdb_valid && ent_d[i].rs2 == cdb_pd) ent_d[i].r2 = 1'b1;
      if (disp_fire && i == int'(wr)) ent_d[i] = disp_ent;
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  // state registers; holdoff spaces issues until the unit reports busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      hold_q  <= fu_start;
    end
endmodule

// File: tb/tb_br_issue_sched.sv
// tb_br_issue_sched: directed self-checking bench for br_issue_sched
module tb_br_issue_sched;
  logic                 clk = 1'b0, rst_n = 1'b0;
  logic                 disp_valid = 1'b0, disp_ready;
  br_pkg::decode_info_t disp_info = '0, fu_info;
  logic [5:0]           disp_rs1_paddr = '0, disp_rs2_paddr = '0, disp_pd = '0;
  logic                 disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic [4:0]           disp_rob_idx = '0, fu_rob_idx;
  logic                 cdb_valid = 1'b0, flush = 1'b0, fu_busy, fu_start;
  logic [5:0]           cdb_pd = '0, fu_rs1_paddr, fu_rs2_paddr, fu_pd;
  logic [2:0]           count;
  logic                 busy_en = 1'b0, s1 = 1'b0, s2 = 1'b0;
  int                   n_cmp = 0, n_err = 0;

  br_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_info(disp_info), .disp_rs1_paddr(disp_rs1_paddr), .disp_rs2_paddr(disp_rs2_paddr),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy), .disp_pd(disp_pd),
    .disp_rob_idx(disp_rob_idx), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .fu_busy(fu_busy),
    .fu_start(fu_start), .fu_info(fu_info), .fu_rs1_paddr(fu_rs1_paddr),
    .fu_rs2_paddr(fu_rs2_paddr), .fu_pd(fu_pd), .fu_rob_idx(fu_rob_idx), .flush(flush),
    .count(count)
  );

  always #5 clk = ~clk;

  // branch unit: busy for two cycles after each start
  always_ff @(posedge clk) begin
    s1 <= fu_start;
    s2 <= s1;
  end
  assign fu_busy = busy_en && (s1 || s2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [5:0] rs1, input logic r1,
                      input logic [5:0] rs2, input logic r2, input logic [5:0] pd,
                      input logic [4:0] rob);
    disp_valid     = 1'b1;
    disp_info      = '0;
    disp_info.pc   = pc;
    disp_info.opcode = 7'h6f;
    disp_rs1_paddr = rs1;
    disp_rs1_rdy   = r1;
    disp_rs2_paddr = rs2;
    disp_rs2_rdy   = r2;
    disp_pd        = pd;
    disp_rob_idx   = rob;
  endtask

  initial begin
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_start", fu_start, 0);
    chk("rst_pd", fu_pd, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // basic issue
    disp(32'h100, 6'd1, 1'b1, 6'd2, 1'b1, 6'd7, 5'd3);
    #1;
    chk("basic_pre", fu_start, 0);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("basic_start", fu_start, 1);
    chk("basic_pc", fu_info.pc, 32'h100);
    chk("basic_pd", fu_pd, 7);
    chk("basic_rob", fu_rob_idx, 3);
    chk("basic_cnt1", count, 1);
    tick();
    chk("basic_cnt0", count, 0);
    chk("basic_idle", fu_start, 0);
    // holdoff with simultaneous dispatch and issue
    disp(32'h300, 6'd1, 1'b1, 6'd2, 1'b1, 6'd20, 5'd1);
    tick();
    disp(32'h304, 6'd1, 1'b1, 6'd2, 1'b1, 6'd21, 5'd2);
    #1;
    chk("hold_x_start", fu_start, 1);
    chk("hold_x_pd", fu_pd, 20);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("hold_cnt", count, 1);
    chk("hold_block", fu_start, 0);
    chk("hold_y_pd", fu_pd, 21);
    tick();
    chk("hold_y_start", fu_start, 1);
    tick();
    chk("hold_cnt0", count, 0);
    // oldest-ready order with busy window
    busy_en = 1'b1;
    disp(32'h0a0, 6'd5, 1'b0, 6'd6, 1'b1, 6'd10, 5'd4);
    tick();
    disp(32'h0b0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd11, 5'd5);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("ord_b_start", fu_start, 1);
    chk("ord_b_pd", fu_pd, 11);
    chk("ord_cnt2", count, 2);
    tick();
    cdb_valid = 1'b1;
    cdb_pd    = 6'd5;
    #1;
    chk("ord_a_notyet", fu_start, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("ord_a_busy", fu_start, 0);
    chk("ord_a_payload", fu_pd, 10);
    tick();
    chk("ord_a_start", fu_start, 1);
    chk("ord_a_pc", fu_info.pc, 32'h0a0);
    tick();
    chk("ord_cnt0", count, 0);
    busy_en = 1'b0;
    tick();
    // full / backpressure
    for (int i = 0; i < 4; i++) begin
      disp(32'h200 + 32'(i * 4), 6'(30 + i), 1'b0, 6'd0, 1'b1, 6'(i + 1), 5'(i));
      tick();
    end
    chk("full_cnt", count, 4);
    chk("full_ready", disp_ready, 0);
    disp(32'h2f0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 5'd9);
    tick();
    disp_valid = 1'b0;
    #1;
    chk("full_drop_cnt", count, 4);
    chk("full_drop_start", fu_start, 0);
    cdb_valid = 1'b1;
    cdb_pd    = 6'd32;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("full_e2_start", fu_start, 1);
    chk("full_e2_pd", fu_pd, 3);
    chk("full_still", disp_ready, 0);
    tick();
    chk("full_cnt3", count, 3);
    chk("full_reopen", disp_ready, 1);
    cdb_valid = 1'b1;
    cdb_pd    = 6'd33;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("shift_start", fu_start, 1);
    chk("shift_pd", fu_pd, 4);
    tick();
    chk("shift_cnt", count, 2);
    // flush with concurrent dispatch
    disp(32'h400, 6'd1, 1'b1, 6'd2, 1'b1, 6'd12, 5'd12);
    tick();
    chk("fl_cnt3", count, 3);
    disp(32'h404, 6'd1, 1'b1, 6'd2, 1'b1, 6'd13, 5'd13);
    flush = 1'b1;
    #1;
    chk("fl_start", fu_start, 0);
    tick();
    flush      = 1'b0;
    disp_valid = 1'b0;
    #1;
    chk("fl_cnt0", count, 0);
    chk("fl_ready", disp_ready, 1);
    chk("fl_nostore", fu_start, 0);
    // dispatch bypass
    disp(32'h500, 6'd9, 1'b0, 6'd1, 1'b1, 6'd14, 5'd14);
    cdb_valid = 1'b1;
    cdb_pd    = 6'd9;
    tick();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    #1;
    chk("byp_start", fu_start, 1);
    chk("byp_rs1", fu_rs1_paddr, 9);
    tick();
    // async reset mid-operation
    disp(32'h600, 6'd40, 1'b0, 6'd1, 1'b1, 6'd15, 5'd1);
    tick();
    tick();
    disp_valid = 1'b0;
    #1;
    chk("ar_cnt2", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt0", count, 0);
    chk("ar_ready", disp_ready, 1);
    chk("ar_start", fu_start, 0);
    tick();
    rst_n     = 1'b1;
    cdb_valid = 1'b1;
    cdb_pd    = 6'd40;
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("ar_noissue", fu_start, 0);
    chk("ar_cnt_after", count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
